// File: rtl/param_bus_arbiter.sv
// Two-requester round-robin arbiter for the synth parameter bus.
// Each accepted write is played out as a setup / strobe / hold cycle on shared lines.
module param_bus_arbiter #(
    parameter int unsigned ADR_WIDTH  = 7,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                  sCLK_XVXENVS,
    input  logic                  iRST,
    input  logic                  req0_valid,
    input  logic [1:0]            req0_bank,
    input  logic [ADR_WIDTH-1:0]  req0_adr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [1:0]            req1_bank,
    input  logic [ADR_WIDTH-1:0]  req1_adr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADR_WIDTH-1:0]  adr,
    output logic                  write,
    output logic                  osc_sel,
    output logic                  com_sel,
    output logic                  m1_sel,
    output logic                  m2_sel,
    output logic                  busy,
    output logic                  grant_id
);

    localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [3:0]              sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADR_WIDTH-1:0]    adr_q, adr_d;
    logic                    busy_q, busy_d;
    logic                    grant_id_q, grant_id_d;
    logic                    last_grant_q, last_grant_d;

    logic                    idle_c;
    logic                    gnt_c;
    logic                    accept_c;
    logic [1:0]              bank_c;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        idle_c = (state_q == S_IDLE);
        if (req0_valid && req1_valid) begin
            gnt_c = ~last_grant_q;
        end else begin
            gnt_c = req1_valid;
        end
        req0_ready = idle_c && req0_valid && !gnt_c;
        req1_ready = idle_c && req1_valid && gnt_c;
        accept_c   = req0_ready || req1_ready;
        bank_c     = gnt_c ? req1_bank : req0_bank;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        sel_d        = sel_q;
        data_d       = data_q;
        adr_d        = adr_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d      = S_SETUP;
                    cnt_d        = CNT_W'(SETUP_CYC - 1);
                    data_d       = gnt_c ? req1_data : req0_data;
                    adr_d        = gnt_c ? req1_adr : req0_adr;
                    grant_id_d   = gnt_c;
                    last_grant_d = gnt_c;
                    unique case (bank_c)
                        2'd0:    sel_d = 4'b0001;
                        2'd1:    sel_d = 4'b0010;
                        2'd2:    sel_d = 4'b0100;
                        default: sel_d = 4'b1000;
                    endcase
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = CNT_W'(STROBE_CYC - 1);
                    write_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    write_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    sel_d   = 4'b0000;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                write_d = 1'b1;
                sel_d   = 4'b0000;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sCLK_XVXENVS) begin
        if (iRST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b1;
            sel_q        <= 4'b0000;
            data_q       <= '0;
            adr_q        <= '0;
            busy_q       <= 1'b0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            adr_q        <= adr_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign data     = data_q;
    assign adr      = adr_q;
    assign write    = write_q;
    assign osc_sel  = sel_q[0];
    assign com_sel  = sel_q[1];
    assign m1_sel   = sel_q[2];
    assign m2_sel   = sel_q[3];
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_param_bus_arbiter.sv
// Bench for param_bus_arbiter: two instances (default and 1/3/2 timing) driven by the
// same requesters and compared every cycle against a transaction-level model.
module tb_param_bus_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;
    localparam int S_A = 2, T_A = 2, H_A = 1;
    localparam int S_B = 1, T_B = 3, H_B = 2;
    localparam int IDLE_N = 1000;

    // n = cycles elapsed since the accepting edge (IDLE_N when nothing in flight)
    typedef struct packed {
        int            n;
        logic          last;
        logic          gid;
        logic [1:0]    bank;
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          v0, v1;
    logic [1:0]    b0, b1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    logic          ra0, ra1, wa, busya, gida;
    logic [3:0]    sela;
    logic [AW-1:0] adra;
    logic [DW-1:0] dataa;
    logic          rb0, rb1, wb, busyb, gidb;
    logic [3:0]    selb;
    logic [AW-1:0] adrb;
    logic [DW-1:0] datab;

    param_bus_arbiter #(.ADR_WIDTH(AW), .DATA_WIDTH(DW),
        .SETUP_CYC(S_A), .STROBE_CYC(T_A), .HOLD_CYC(H_A)) u_a (
        .sCLK_XVXENVS(clk), .iRST(rst),
        .req0_valid(v0), .req0_bank(b0), .req0_adr(a0), .req0_data(d0), .req0_ready(ra0),
        .req1_valid(v1), .req1_bank(b1), .req1_adr(a1), .req1_data(d1), .req1_ready(ra1),
        .data(dataa), .adr(adra), .write(wa),
        .osc_sel(sela[0]), .com_sel(sela[1]), .m1_sel(sela[2]), .m2_sel(sela[3]),
        .busy(busya), .grant_id(gida));

    param_bus_arbiter #(.ADR_WIDTH(AW), .DATA_WIDTH(DW),
        .SETUP_CYC(S_B), .STROBE_CYC(T_B), .HOLD_CYC(H_B)) u_b (
        .sCLK_XVXENVS(clk), .iRST(rst),
        .req0_valid(v0), .req0_bank(b0), .req0_adr(a0), .req0_data(d0), .req0_ready(rb0),
        .req1_valid(v1), .req1_bank(b1), .req1_adr(a1), .req1_data(d1), .req1_ready(rb1),
        .data(datab), .adr(adrb), .write(wb),
        .osc_sel(selb[0]), .com_sel(selb[1]), .m1_sel(selb[2]), .m2_sel(selb[3]),
        .busy(busyb), .grant_id(gidb));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wlow_a, wlow_b, r0_cnt;
    logic acc0, acc1;
    logic [3:0] prev_sel_a;
    mdl_t ma, mb;
    int   qa[$];
    int   qb[$];
    logic ga[$];
    logic [3:0] selq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mdl_t reset_model();
        mdl_t r;
        r.n = IDLE_N; r.last = 1'b1; r.gid = 1'b0;
        r.bank = 2'd0; r.adr = '0; r.data = '0;
        return r;
    endfunction

    function automatic logic [1:0] exp_ready(input mdl_t m, input int per);
        logic g;
        if (m.n < per || !(v0 || v1)) return 2'b00;
        g = (v0 && v1) ? !m.last : v1;
        return g ? 2'b10 : 2'b01;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic [1:0] rdy);
        mdl_t r = m;
        if (rst) begin
            r = reset_model();
        end else if (rdy != 2'b00) begin
            r.n = 0; r.gid = rdy[1]; r.last = rdy[1];
            r.bank = rdy[1] ? b1 : b0;
            r.adr  = rdy[1] ? a1 : a0;
            r.data = rdy[1] ? d1 : d0;
        end else if (r.n < IDLE_N) begin
            r.n = r.n + 1;
        end
        return r;
    endfunction

    task automatic check_inst(input string p, input mdl_t m, input int s, input int t, input int h,
                              input logic [1:0] rdy, input logic [1:0] erdy, input logic w,
                              input logic [3:0] sel, input logic bsy, input logic gid,
                              input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        logic act, ew;
        logic [3:0] esel;
        act  = (m.n < s + t + h);
        ew   = !(act && m.n >= s && m.n < s + t);
        esel = act ? (4'b0001 << m.bank) : 4'b0000;
        chk({p, "_ready"}, 32'(rdy), 32'(erdy));
        chk({p, "_write"}, 32'(w), 32'(ew));
        chk({p, "_sel"}, 32'(sel), 32'(esel));
        chk({p, "_busy"}, 32'(bsy), 32'(act));
        chk({p, "_grant_id"}, 32'(gid), 32'(m.gid));
        chk({p, "_adr_data"}, 32'({ad, dt}), 32'({m.adr, m.data}));
        chk({p, "_onehot"}, 32'($countones(sel) <= 1), 32'(1));
        chk({p, "_sel_on_strobe"}, 32'(w || (sel != 4'b0000)), 32'(1));
    endtask

    // One clock: check at the falling edge, advance the models, return just after the rising edge.
    task automatic tick();
        logic [1:0] ea, eb;
        @(negedge clk);
        ea = exp_ready(ma, S_A + T_A + H_A);
        eb = exp_ready(mb, S_B + T_B + H_B);
        check_inst("A", ma, S_A, T_A, H_A, {ra1, ra0}, ea, wa, sela, busya, gida, adra, dataa);
        check_inst("B", mb, S_B, T_B, H_B, {rb1, rb0}, eb, wb, selb, busyb, gidb, adrb, datab);
        acc0 = ra0 && !rst;
        acc1 = ra1 && !rst;
        if (!wa) wlow_a++;
        if (!wb) wlow_b++;
        if (ra0) r0_cnt++;
        if (acc0 || acc1) begin qa.push_back(cyc); ga.push_back(acc1); end
        if ((rb0 || rb1) && !rst) qb.push_back(cyc);
        if (sela != prev_sel_a && sela != 4'b0000) selq.push_back(sela);
        prev_sel_a = sela;
        ma = step(ma, ea);
        mb = step(mb, eb);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_acc(input logic which, input string tag);
        logic got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (which ? acc1 : acc0) begin got = 1'b1; break; end
        end
        chk(tag, 32'(got), 32'(1));
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        b0 = '0; b1 = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        acc0 = 1'b0; acc1 = 1'b0; wlow_a = 0; wlow_b = 0; r0_cnt = 0;
        prev_sel_a = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        ma = reset_model();
        mb = reset_model();

        // Single req0 write right after reset
        reset_dut();
        wlow_a = 0; wlow_b = 0;
        v0 = 1'b1; b0 = 2'd0; a0 = 7'h12; d0 = 8'h55;
        tick();
        chk("t1_ready0_first_cycle", 32'(acc0), 32'(1));
        v0 = 1'b0;
        repeat (8) tick();
        chk("t1_A_write_low_cycles", 32'(wlow_a), 32'(2));
        chk("t1_B_write_low_cycles", 32'(wlow_b), 32'(3));
        chk("t1_adr_kept", 32'(adra), 32'(7'h12));

        // Continuous contention: grants alternate with fixed spacing
        reset_dut();
        qa.delete(); qb.delete(); ga.delete();
        v0 = 1'b1; b0 = 2'd1; a0 = 7'h21; d0 = 8'hA0;
        v1 = 1'b1; b1 = 2'd2; a1 = 7'h42; d1 = 8'h0B;
        repeat (26) tick();
        v0 = 1'b0; v1 = 1'b0;
        chk("A_accept_count", 32'(qa.size()), 32'(5));
        chk("B_accept_count", 32'(qb.size()), 32'(4));
        for (int i = 0; i < qa.size(); i++) chk("A_grant_order", 32'(ga[i]), 32'(i % 2));
        for (int i = 1; i < qa.size(); i++) chk("A_period", 32'(qa[i] - qa[i-1]), 32'(6));
        for (int i = 1; i < qb.size(); i++) chk("B_period", 32'(qb[i] - qb[i-1]), 32'(7));

        // req1 alone sweeps all four banks
        reset_dut();
        selq.delete();
        for (int bk = 0; bk < 4; bk++) begin
            v1 = 1'b1; b1 = 2'(bk); a1 = AW'($urandom); d1 = DW'($urandom);
            wait_acc(1'b1, "sweep_accept");
        end
        v1 = 1'b0;
        repeat (8) tick();
        chk("sweep_count", 32'(selq.size()), 32'(4));
        for (int i = 0; i < selq.size() && i < 4; i++)
            chk("sweep_bank_order", 32'(selq[i]), 32'(1 << i));

        // Reset while write is low, then a fresh request
        reset_dut();
        v0 = 1'b1; b0 = 2'd3; a0 = 7'h05; d0 = 8'hC3;
        wait_acc(1'b0, "strobe_accept");
        v0 = 1'b0;
        for (int i = 0; i < 20 && wa; i++) tick();
        chk("strobe_reached", 32'(wa), 32'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_write", 32'(wa), 32'(1));
        chk("rst_mid_sel", 32'(sela), 32'(0));
        chk("rst_mid_busy", 32'(busya), 32'(0));
        v0 = 1'b1; b0 = 2'd2; a0 = 7'h33; d0 = 8'h3C;
        wait_acc(1'b0, "rst_rearm_accept");
        v0 = 1'b0;
        repeat (8) tick();

        // req0 withdrawn while req1 owns the bus
        reset_dut();
        v1 = 1'b1; b1 = 2'd1; a1 = 7'h11; d1 = 8'h22;
        wait_acc(1'b1, "drop_req1_accept");
        v1 = 1'b0;
        r0_cnt = 0;
        v0 = 1'b1; b0 = 2'd0; a0 = 7'h7F; d0 = 8'hFF;
        repeat (2) tick();
        v0 = 1'b0;
        repeat (6) tick();
        chk("drop_req0_never_ready", 32'(r0_cnt), 32'(0));

        // Randomized traffic with occasional resets
        reset_dut();
        acc0 = 1'b0; acc1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!v0 || acc0) begin
                v0 = 1'($urandom_range(0, 1)); b0 = 2'($urandom);
                a0 = AW'($urandom); d0 = DW'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                v0 = 1'b0;
            end
            if (!v1 || acc1) begin
                v1 = 1'($urandom_range(0, 1)); b1 = 2'($urandom);
                a1 = AW'($urandom); d1 = DW'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                v1 = 1'b0;
            end
            rst = 1'($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
